// File: rtl/uart_slip_decoder.sv
`default_nettype none
// uart_slip_decoder: decodes a SLIP (RFC 1055) byte stream into payload bytes with an
// end-of-packet marker. Malformed and oversize packets are dropped and counted.
module uart_slip_decoder #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_rx_ready,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output logic             o_last,
  input  logic             i_ready,
  output logic [LEN_W-1:0] o_pkt_len,
  output logic             o_pkt_done,
  output logic [7:0]       o_err_count
);

  localparam logic [7:0]       END_C     = 8'hC0;
  localparam logic [7:0]       ESC_C     = 8'hDB;
  localparam logic [7:0]       ESC_END_C = 8'hDC;
  localparam logic [7:0]       ESC_ESC_C = 8'hDD;
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ESCAPE  = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             hold_v_q, hold_v_d;
  logic [7:0]       hold_d_q, hold_d_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_done_q, pkt_done_d;
  logic [7:0]       err_q, err_d;

  logic             rx_fire, out_fire, pay_v, err;
  logic [7:0]       pay_b;

  assign o_rx_ready  = !valid_q || i_ready;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_last      = last_q;
  assign o_pkt_len   = pkt_len_q;
  assign o_pkt_done  = pkt_done_q;
  assign o_err_count = err_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_NORMAL;
      hold_v_q   <= 1'b0;
      hold_d_q   <= 8'd0;
      len_q      <= '0;
      pend_len_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      last_q     <= 1'b0;
      pkt_len_q  <= '0;
      pkt_done_q <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_v_q   <= hold_v_d;
      hold_d_q   <= hold_d_d;
      len_q      <= len_d;
      pend_len_q <= pend_len_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      pkt_len_q  <= pkt_len_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_v_d   = hold_v_q;
    hold_d_d   = hold_d_q;
    len_d      = len_q;
    pend_len_d = pend_len_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    pkt_len_d  = pkt_len_q;
    pkt_done_d = 1'b0;
    err_d      = err_q;
    pay_v      = 1'b0;
    pay_b      = 8'd0;
    err        = 1'b0;

    rx_fire  = i_rx_valid && o_rx_ready;
    out_fire = valid_q && i_ready;

    if (out_fire) begin
      valid_d = 1'b0;
      if (last_q) begin
        pkt_done_d = 1'b1;
        pkt_len_d  = pend_len_q;
      end
    end

    if (rx_fire) begin
      case (state_q)
        ST_NORMAL: begin
          if (i_rx_data == END_C) begin
            if (hold_v_q) begin
              valid_d    = 1'b1;
              data_d     = hold_d_q;
              last_d     = 1'b1;
              hold_v_d   = 1'b0;
              pend_len_d = len_q;
              len_d      = '0;
            end
          end else if (i_rx_data == ESC_C) begin
            state_d = ST_ESCAPE;
          end else begin
            pay_v = 1'b1;
            pay_b = i_rx_data;
          end
        end
        ST_ESCAPE: begin
          state_d = ST_NORMAL;
          if (i_rx_data == ESC_END_C) begin
            pay_v = 1'b1;
            pay_b = END_C;
          end else if (i_rx_data == ESC_ESC_C) begin
            pay_v = 1'b1;
            pay_b = ESC_C;
          end else begin
            err = 1'b1;
            if (i_rx_data != END_C) state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (i_rx_data == END_C) state_d = ST_NORMAL;
        end
        default: state_d = ST_NORMAL;
      endcase
    end

    // The held byte is only released once a following payload byte proves it is not the last.
    if (pay_v) begin
      if (len_q == MAX_LEN_C) begin
        err     = 1'b1;
        state_d = ST_DISCARD;
      end else begin
        if (hold_v_q) begin
          valid_d = 1'b1;
          data_d  = hold_d_q;
          last_d  = 1'b0;
        end
        hold_d_d = pay_b;
        hold_v_d = 1'b1;
        len_d    = len_q + LEN_W'(1);
      end
    end

    if (err) begin
      hold_v_d = 1'b0;
      len_d    = '0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_slip_decoder.sv
`default_nettype none
// tb_uart_slip_decoder: directed vector table, backpressure/reset sequences and a random
// stream checked against a frame-level SLIP reference model.
module tb_uart_slip_decoder;

  localparam int MAXL = 4;
  localparam int LW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          o_valid;
  logic [7:0]    o_data;
  logic          o_last;
  logic          i_ready;
  logic [LW-1:0] pkt_len;
  logic          pkt_done;
  logic [7:0]    err_count;

  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_bit   = 1'b1;
  logic gap_rand  = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [8:0]    act_q[$];
  logic [LW-1:0] len_q[$];
  logic [7:0]    sq[$];
  logic [8:0]    exp_q[$];
  logic [LW-1:0] explen_q[$];
  int            m_err;

  assign i_ready = rdy_rand ? rnd_bit : rdy_force;

  always #5 clk = ~clk;

  uart_slip_decoder #(.MAX_LEN(MAXL), .LEN_W(LW)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_ready (rx_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_pkt_len  (pkt_len),
    .o_pkt_done (pkt_done),
    .o_err_count(err_count)
  );

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom % 10) < 7;
  end

  // Output handshakes complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) act_q.push_back({o_last, o_data});
      if (pkt_done) len_q.push_back(pkt_len);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    if (gap_rand) idle($urandom % 3);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    rx_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no o_rx_ready expected accept of %0h", b);
    end
  endtask

  // Frame-level model: every END delimits a frame regardless of decoder state.
  task automatic decode_frame(input logic [7:0] fr[$]);
    logic [7:0] dec[$];
    logic [7:0] b;
    bit         err = 0;
    int         j = 0;
    while (j < fr.size() && !err) begin
      if (fr[j] == 8'hDB) begin
        if (j + 1 < fr.size() && fr[j+1] == 8'hDC) b = 8'hC0;
        else if (j + 1 < fr.size() && fr[j+1] == 8'hDD) b = 8'hDB;
        else err = 1;
        j += 2;
      end else begin
        b = fr[j];
        j++;
      end
      if (!err) begin
        if (dec.size() == MAXL) err = 1;
        else dec.push_back(b);
      end
    end
    if (err) begin
      if (m_err < 255) m_err++;
      for (int k = 0; k < dec.size() - 1; k++) exp_q.push_back({1'b0, dec[k]});
    end else if (dec.size() > 0) begin
      for (int k = 0; k < dec.size(); k++) exp_q.push_back({k == dec.size() - 1, dec[k]});
      explen_q.push_back(LW'(dec.size()));
    end
  endtask

  task automatic run_model();
    logic [7:0] fr[$];
    foreach (sq[i]) begin
      if (sq[i] == 8'hC0) begin
        decode_frame(fr);
        fr.delete();
      end else begin
        fr.push_back(sq[i]);
      end
    end
  endtask

  typedef struct packed {
    logic [63:0] in_b;
    logic [3:0]  n_in;
    logic [31:0] ex_d;
    logic [3:0]  ex_l;
    logic [2:0]  n_ex;
    logic [7:0]  ex_err;
    logic [1:0]  n_pkt;
    logic [15:0] ex_len;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{64'hC0010203C0000000, 4'd5, 32'h01020300, 4'b0010, 3'd3, 8'd0, 2'd1, 16'd3};
    vt[1] = '{64'hC0DBDCDBDD7EC000, 4'd7, 32'hC0DB7E00, 4'b0010, 3'd3, 8'd0, 2'd1, 16'd3};
    vt[2] = '{64'hC0C0C055C0000000, 4'd5, 32'h55000000, 4'b1000, 3'd1, 8'd0, 2'd1, 16'd1};
    vt[3] = '{64'h11DB2233C044C000, 4'd7, 32'h44000000, 4'b1000, 3'd1, 8'd1, 2'd1, 16'd1};
    vt[4] = '{64'hC00102030405C000, 4'd7, 32'h01020300, 4'b0000, 3'd3, 8'd2, 2'd0, 16'd0};
    vt[5] = '{64'hAABBC00000000000, 4'd3, 32'hAABB0000, 4'b0100, 3'd2, 8'd2, 2'd1, 16'd2};
    vt[6] = '{64'hC0A1A2A3A4C00000, 4'd6, 32'hA1A2A3A4, 4'b0001, 3'd4, 8'd2, 2'd1, 16'd4};
    vt[7] = '{64'h10DBC020C0000000, 4'd5, 32'h20000000, 4'b1000, 3'd1, 8'd3, 2'd1, 16'd1};
    vt[8] = '{64'hDBDCC00000000000, 4'd3, 32'hC0000000, 4'b1000, 3'd1, 8'd3, 2'd1, 16'd1};

    idle(3);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_len", pkt_len, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 9; v++) begin
      act_q.delete();
      len_q.delete();
      for (int i = 0; i < vt[v].n_in; i++) send_byte(vt[v].in_b[63-8*i -: 8]);
      idle(5);
      chk($sformatf("v%0d_nout", v), act_q.size(), vt[v].n_ex);
      for (int j = 0; j < vt[v].n_ex; j++)
        if (j < act_q.size())
          chk($sformatf("v%0d_byte%0d", v, j), act_q[j], {vt[v].ex_l[3-j], vt[v].ex_d[31-8*j -: 8]});
      chk($sformatf("v%0d_err", v), err_count, vt[v].ex_err);
      chk($sformatf("v%0d_npkt", v), len_q.size(), vt[v].n_pkt);
      if (vt[v].n_pkt != 0 && len_q.size() != 0)
        chk($sformatf("v%0d_len", v), len_q[len_q.size()-1], vt[v].ex_len);
    end

    // Backpressure mid-packet with input pending.
    act_q.delete();
    len_q.delete();
    send_byte(8'hC0);
    send_byte(8'h61);
    send_byte(8'h62);
    rdy_force = 1'b0;
    rx_valid  = 1'b1;
    rx_data   = 8'h63;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rx_ready", rx_ready, 0);
      chk("bp_valid", o_valid, 1);
      chk("bp_data", o_data, 8'h61);
    end
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rdy_force = 1'b1;
    send_byte(8'h63);
    send_byte(8'h64);
    send_byte(8'hC0);
    idle(5);
    chk("bp_nout", act_q.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < act_q.size()) chk($sformatf("bp_byte%0d", j), act_q[j], {j == 3, 8'h61 + 8'(j)});
    chk("bp_npkt", len_q.size(), 1);
    if (len_q.size() != 0) chk("bp_len", len_q[0], 4);

    // Reset while a byte is presented and another is held.
    act_q.delete();
    len_q.delete();
    send_byte(8'hC0);
    send_byte(8'h71);
    send_byte(8'h72);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", o_valid, 0);
    chk("mr_data", o_data, 0);
    chk("mr_last", o_last, 0);
    chk("mr_err", err_count, 0);
    chk("mr_len", pkt_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_byte(8'h73);
    send_byte(8'hC0);
    idle(5);
    chk("mr_nout", act_q.size(), 1);
    if (act_q.size() != 0) chk("mr_byte", act_q[0], {1'b1, 8'h73});

    // Random stream against the frame model.
    act_q.delete();
    len_q.delete();
    exp_q.delete();
    explen_q.delete();
    m_err = 0;
    for (int p = 0; p < 150; p++) begin
      int n = $urandom_range(0, 6);
      for (int e = 0; e < n; e++) begin
        int r = $urandom % 16;
        if (r == 0) begin sq.push_back(8'hDB); sq.push_back(8'hDC); end
        else if (r == 1) begin sq.push_back(8'hDB); sq.push_back(8'hDD); end
        else if (r == 2) begin sq.push_back(8'hDB); sq.push_back(8'($urandom)); end
        else if (r == 3) sq.push_back(8'hC0);
        else sq.push_back(8'($urandom));
      end
      sq.push_back(8'hC0);
    end
    run_model();
    rdy_rand = 1'b1;
    gap_rand = 1'b1;
    foreach (sq[i]) send_byte(sq[i]);
    rdy_rand = 1'b0;
    gap_rand = 1'b0;
    idle(10);
    chk("rnd_nout", act_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
      chk($sformatf("rnd_byte%0d", k), act_q[k], exp_q[k]);
    chk("rnd_npkt", len_q.size(), explen_q.size());
    for (int k = 0; k < explen_q.size() && k < len_q.size(); k++)
      chk($sformatf("rnd_len%0d", k), len_q[k], explen_q[k]);
    chk("rnd_err", err_count, m_err);

    // Error counter saturation.
    act_q.delete();
    for (int p = 0; p < 260; p++) begin
      send_byte(8'hDB);
      send_byte(8'h01);
      send_byte(8'hC0);
    end
    idle(3);
    chk("sat_err", err_count, 8'hFF);
    chk("sat_nout", act_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_slip_decoder.md
Name: uart_slip_decoder

Overview:
- Downstream consumer of the UART receive byte stream. Takes raw bytes from the RX byte FIFO read side and decodes SLIP framing (RFC 1055).
- Emits unescaped payload bytes with an end-of-packet marker, so the host-interface and loader logic can work on whole packets.
- Drops malformed packets and oversize packets, and counts them.

Parameters:
MAX_LEN, 1024, maximum payload bytes per packet; longer packets are discarded.
LEN_W, 16, width of the packet length counter; must satisfy 2^LEN_W > MAX_LEN.

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_rx_valid  in  1  input byte available
i_rx_data  in  8  input byte
o_rx_ready  out  1  decoder accepts input this cycle
o_valid  out  1  output byte valid
o_data  out  8  decoded payload byte
o_last  out  1  o_data is final byte of packet
i_ready  in  1  downstream accepts output this cycle
o_pkt_len  out  LEN_W  length of last completed packet, valid when o_pkt_done
o_pkt_done  out  1  one-cycle strobe on the handshake of an o_last byte
o_err_count  out  8  saturating count of discarded packets

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_data=0, o_last=0, o_pkt_len=0, o_pkt_done=0, o_err_count=0. State NORMAL, hold register empty, length counter 0. A reset mid-packet discards all partial data.
- Input handshake: a byte is consumed when i_rx_valid && o_rx_ready. o_rx_ready = !o_valid || i_ready (combinational). Output handshake: o_valid && i_ready.
- Output register: o_valid/o_data/o_last hold stable until accepted.
- One-byte hold register (hold_v, hold_d) delays each payload byte by one symbol, so o_last can mark the byte that precedes END.
- Codes: END=0xC0, ESC=0xDB, ESC_END=0xDC, ESC_ESC=0xDD.
- State NORMAL:
  - END with hold_v: emit hold_d with o_last=1; clear hold; length counter to 0.
  - END without hold_v (empty packet or back-to-back END): ignored, nothing emitted.
  - ESC: go to ESCAPE.
  - Any other byte b: this is a payload byte; run the payload-byte step with b.
- State ESCAPE:
  - 0xDC: payload byte 0xC0.
  - 0xDD: payload byte 0xDB.
  - END: error; drop packet, back to NORMAL.
  - Any other byte: error; go to DISCARD.
  - After a valid escape, return to NORMAL.
- State DISCARD: consume and drop bytes until END, then go to NORMAL. Nothing is emitted.
- Payload-byte step with byte b:
  - If the length counter already equals MAX_LEN: error, go to DISCARD.
  - Else if hold_v: emit hold_d with o_last=0.
  - Then hold_d=b, hold_v=1, length counter +1.
- Error action (always the same): clear hold_v, length counter to 0, o_err_count +1 saturating at 255. No partial last byte is emitted; a packet already partly emitted stays truncated with no o_last.
- Latency: a payload byte appears on o_data in the cycle after the input handshake of the next symbol that releases it (the next payload byte or END).
- o_pkt_done: one-cycle strobe in the cycle after the o_last byte is handshaked. o_pkt_len is updated in that same cycle to the packet's byte count. The count is latched when END is consumed.
- Backpressure: when i_ready=0 with o_valid=1, o_rx_ready=0 and no input is consumed. State, hold register and counter are frozen.
- Counter width: the length counter is LEN_W bits and never exceeds MAX_LEN.

Test Plan:
- Feed C0 01 02 03 C0 with i_ready=1 -> outputs 01,02,03; o_last only on 03; o_pkt_done pulses once with o_pkt_len=3; o_err_count=0.
- Feed C0 DB DC DB DD 7E C0 -> outputs C0,DB,7E; o_last on 7E; o_pkt_len=3.
- Feed C0 C0 C0 55 C0 -> only 55 emitted, with o_last=1; empty packets produce no output and no error.
- Feed 11 DB 22 33 C0 44 C0 -> 22 and 33 dropped; o_err_count=1; next packet emits 44 with o_last; o_pkt_len=1.
- Set MAX_LEN=4; feed 5 payload bytes then C0, followed by 2-byte packet AA BB C0 -> first packet errors (o_err_count=1, no o_last); second emits AA, BB(last) and o_pkt_len=2.
- Hold i_ready=0 for 10 cycles mid-packet with i_rx_valid=1 -> o_rx_ready=0, o_data stable. Release -> byte order intact, no loss or duplication. Assert i_reset_n=0 mid-packet -> all outputs 0 immediately, next packet decodes cleanly.
